// File: rtl/if_prefetch_stage_if.sv
// Instruction-memory request/response bus for the fetch stage.
// The fetch stage is the master; the memory is the slave.
interface if_prefetch_stage_if #(
  parameter int WIDTH = 32
) ();
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ready;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction fetch: PC generator, single-outstanding imem FSM
// and a DEPTH-entry prefetch queue feeding the IF/ID register.
module if_prefetch_stage #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Haz_Det,
  input  logic                brTaken,
  input  logic [WIDTH-1:0]    brPC,
  input  logic [WIDTH-1:0]    brOffset,
  if_prefetch_stage_if.master imem,
  output logic [WIDTH-1:0]    PC,
  output logic [WIDTH-1:0]    instruction,
  output logic                if_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic [WIDTH-1:0] hold_ins_q, hold_ins_d;

  logic [WIDTH-1:0] pc_mem_q  [DEPTH];
  logic [WIDTH-1:0] ins_mem_q [DEPTH];

  logic             push;
  logic             pop;
  logic             accept;
  logic [WIDTH-1:0] br_target;

  assign br_target = brPC + (brOffset << 2);

  assign if_valid = (count_q != '0);
  assign pop      = if_valid && !Haz_Det && !brTaken;
  assign push     = (state_q == WAIT) && imem.imem_rvalid && !brTaken;

  // One request in flight at a time, so a free slot now stays free.
  assign imem.imem_req  = (state_q == IDLE) && !brTaken && !reset &&
                          (count_q < CW'(DEPTH));
  assign imem.imem_addr = fetch_pc_q;
  assign accept         = imem.imem_req && imem.imem_ready;

  assign PC          = if_valid ? pc_mem_q[rd_ptr_q]  : hold_pc_q;
  assign instruction = if_valid ? ins_mem_q[rd_ptr_q] : hold_ins_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pend_pc_d  = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + WIDTH'(4);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          state_d = IDLE;
        end else if (brTaken) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imem.imem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (brTaken) begin
      fetch_pc_d = br_target;
    end
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    hold_pc_d  = PC;
    hold_ins_d = instruction;
    if (brTaken) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      hold_pc_q  <= '0;
      hold_ins_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      hold_pc_q  <= hold_pc_d;
      hold_ins_q <= hold_ins_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem_q[wr_ptr_q]  <= pend_pc_q;
      ins_mem_q[wr_ptr_q] <= imem.imem_rdata;
    end
  end

endmodule
